// File: rtl/mini_src_mem_responder.sv
// Mini SRC memory responder: services Read/Write strobes from an internal word RAM.
// Latency: done pulses WAIT_STATES+1 edges after acceptance; held strobes produce a single access.
module mini_src_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              done,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               op_wr_q, op_wr_d;
    logic [DATA_W-1:0]  mdat_q, mdat_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               mem_we;
    logic               in_range;
    logic [IDX_W-1:0]   idx;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Full-width compare so addresses above DEPTH never alias onto low words.
    assign in_range = (addr_q < ADDR_W'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        mdat_d  = mdat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Read && Write) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (Read || Write) begin
                    addr_d  = addr;
                    op_wr_d = Write;
                    if (Write) begin
                        wdata_d = wdata;
                    end
                    cnt_d   = 4'(WAIT_STATES);
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done_d  = 1'b1;
                    err_d   = ~in_range;
                    state_d = S_DONE;
                    if (op_wr_q) begin
                        mem_we = in_range;
                    end else begin
                        mdat_d = in_range ? mem[idx] : '0;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = (Read || Write) ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!Read && !Write) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            mdat_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            mdat_q  <= mdat_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; mem_we is only ever set from S_WAIT, so reset blocks pending writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign Mdatain = mdat_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mini_src_mem_responder.sv
// Bench for mini_src_mem_responder: four instances (WAIT_STATES 0,1,3,4) share one stimulus stream.
module tb_mini_src_mem_responder;
    logic              clk = 1'b0;
    logic              clr;
    logic              Read, Write;
    logic [31:0]       addr, wdata;
    logic [3:0][31:0]  md;
    logic [3:0]        dn, bs, er;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mini_src_mem_responder #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(512),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4)
        ) u_dut (
            .clk(clk), .clr(clr), .Read(Read), .Write(Write), .addr(addr), .wdata(wdata),
            .Mdatain(md[g]), .done(dn[g]), .busy(bs[g]), .err(er[g])
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: a request accepted at edge e0 completes at edge e0+WS+1; busy spans those edges.
    int          cyc;
    int          e0_m [4];
    int          acc_m [4];
    int          errc_m [4];
    bit          inflt_m [4];
    bit          needlow_m [4];
    bit          wr_m [4];
    bit          oor_m [4];
    logic [31:0] a_m [4];
    logic [31:0] d_m [4];
    logic [31:0] mdat_m [4];
    logic [31:0] mem_m [4][512];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            cyc <= 0;
            for (int i = 0; i < 4; i++) begin
                inflt_m[i]   <= 1'b0;
                needlow_m[i] <= 1'b0;
                mdat_m[i]    <= '0;
                errc_m[i]    <= -10;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 4; i++) begin
                if (inflt_m[i]) begin
                    if (cyc + 1 == acc_m[i]) begin
                        if (oor_m[i]) begin
                            if (!wr_m[i]) mdat_m[i] <= '0;
                        end else if (wr_m[i]) begin
                            mem_m[i][a_m[i][8:0]] <= d_m[i];
                        end else begin
                            mdat_m[i] <= mem_m[i][a_m[i][8:0]];
                        end
                    end else if (cyc + 1 == acc_m[i] + 1) begin
                        inflt_m[i]   <= 1'b0;
                        needlow_m[i] <= Read || Write;
                    end
                end else if (needlow_m[i]) begin
                    if (!Read && !Write) needlow_m[i] <= 1'b0;
                end else if (Read && Write) begin
                    errc_m[i]    <= cyc + 1;
                    needlow_m[i] <= 1'b1;
                end else if (Read || Write) begin
                    inflt_m[i] <= 1'b1;
                    e0_m[i]    <= cyc + 1;
                    acc_m[i]   <= cyc + 1 + ws_of(i) + 1;
                    wr_m[i]    <= Write;
                    a_m[i]     <= addr;
                    d_m[i]     <= wdata;
                    oor_m[i]   <= (addr >= 32'd512);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mdatain[%0d]", i), md[i], mdat_m[i]);
            chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(inflt_m[i] && cyc == acc_m[i]));
            chk($sformatf("busy[%0d]", i), 32'(bs[i]), 32'(inflt_m[i]));
            chk($sformatf("err[%0d]", i), 32'(er[i]),
                32'((inflt_m[i] && cyc == acc_m[i] && oor_m[i]) || errc_m[i] == cyc));
        end
    end

    int lat [4];
    int ndone [4];
    int nerr [4];
    int nbusy [4];

    // Drive a request at a negedge, hold it `hold` cycles, then observe 14 cycles.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold);
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1; ndone[i] = 0; nerr[i] = 0; nbusy[i] = 0;
        end
        Read = rd; Write = wr; addr = a; wdata = d;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (dn[i]) begin
                    if (ndone[i] == 0) lat[i] = k - 1;
                    ndone[i]++;
                end
                if (er[i]) nerr[i]++;
                if (bs[i]) nbusy[i]++;
            end
            if (k == hold) begin
                Read = 1'b0; Write = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; Read = 1'b0; Write = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_md[%0d]", i), md[i], 32'h0);
            chk($sformatf("rst_flags[%0d]", i), {29'b0, dn[i], bs[i], er[i]}, 32'h0);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        req(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 1);
        chk("wr_busy_cycles", nbusy[1], 3);
        chk("wr_done_count", ndone[1], 1);
        chk("wr_err_count", nerr[1], 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_lat[%0d]", i), lat[i], ws_of(i) + 1);
            chk($sformatf("wr_md_unchanged[%0d]", i), md[i], 32'h0);
        end
        req(1'b0, 1'b1, 32'h0, 32'h11111111, 1);
        req(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1);

        req(1'b1, 1'b0, 32'h5, 32'h0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("held_rd_one_done[%0d]", i), ndone[i], 1);
            chk($sformatf("held_rd_lat[%0d]", i), lat[i], ws_of(i) + 1);
            chk($sformatf("held_rd_data[%0d]", i), md[i], 32'hDEADBEEF);
        end

        req(1'b1, 1'b1, 32'h5, 32'h00000BAD, 3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("illegal_err[%0d]", i), nerr[i], 1);
            chk($sformatf("illegal_done[%0d]", i), ndone[i], 0);
            chk($sformatf("illegal_busy[%0d]", i), nbusy[i], 0);
        end
        req(1'b1, 1'b0, 32'h5, 32'h0, 1);
        chk("illegal_ram_kept", md[1], 32'hDEADBEEF);

        req(1'b1, 1'b0, 32'h200, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("oor_rd_done[%0d]", i), ndone[i], 1);
            chk($sformatf("oor_rd_err[%0d]", i), nerr[i], 1);
            chk($sformatf("oor_rd_md[%0d]", i), md[i], 32'h0);
        end
        req(1'b0, 1'b1, 32'h200, 32'h12345678, 1);
        chk("oor_wr_err", nerr[2], 1);
        req(1'b1, 1'b0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("oor_no_alias[%0d]", i), md[i], 32'h11111111);

        // Reset lands just after edge E0+1: only the zero-wait instance has already committed.
        Read = 1'b0; Write = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0; Write = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_md[%0d]", i), md[i], 32'h0);
            chk($sformatf("midrst_flags[%0d]", i), {29'b0, dn[i], bs[i], er[i]}, 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        req(1'b1, 1'b0, 32'h10, 32'h0, 1);
        chk("midrst_ws0_committed", md[0], 32'hCAFEF00D);
        for (int i = 1; i < 4; i++) chk($sformatf("midrst_aborted[%0d]", i), md[i], 32'h0BADF00D);

        for (int r = 0; r < 2; r++) begin
            req(1'b1, 1'b0, 32'h5, 32'h0, 1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sweep%0d_lat[%0d]", r, i), lat[i], ws_of(i) + 1);
                chk($sformatf("sweep%0d_md[%0d]", r, i), md[i], 32'hDEADBEEF);
            end
        end
        chk("sweep_lat_ws4", lat[3], 5);
        chk("sweep_lat_ws0", lat[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
